// File: rtl/imem_load_if.sv
// Bus bundle between the instruction-memory load controller and its
// surroundings (boot loader, instruction memory, fetch stage).
//
// Loader side  : ld_valid, ld_ready, ld_data, ld_last, reload
// Fetch side   : fetch_addr, instr_out, core_hold, core_flush
// Memory side  : mem_addr, mem_we, mem_wdata, mem_rdata
// Status       : load_end (byte address one past the program), load_err
//
// slave  : the controller's view
// master : the environment's view (loader, memory, fetch stage)
interface imem_load_if;
    logic        ld_valid;
    logic        ld_ready;
    logic [15:0] ld_data;
    logic        ld_last;
    logic        reload;
    logic [15:0] fetch_addr;
    logic [15:0] mem_rdata;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] instr_out;
    logic        core_hold;
    logic        core_flush;
    logic [15:0] load_end;
    logic        load_err;

    modport slave (
        input  ld_valid, ld_data, ld_last, reload, fetch_addr, mem_rdata,
        output ld_ready, mem_addr, mem_we, mem_wdata, instr_out,
               core_hold, core_flush, load_end, load_err
    );

    modport master (
        output ld_valid, ld_data, ld_last, reload, fetch_addr, mem_rdata,
        input  ld_ready, mem_addr, mem_we, mem_wdata, instr_out,
               core_hold, core_flush, load_end, load_err
    );
endinterface

// File: rtl/imem_load_controller.sv
// Instruction-memory load controller.
//
// After reset the core is held while a loader streams words into
// consecutive instruction slots (address = slot * ADDR_STEP). The final
// word (ld_last) records load_end, flushes the pipeline for one cycle and
// releases the core. In RUN the fetch stage reads the memory directly;
// fetches at or beyond load_end return NOP_WORD. Overfilling the memory
// without ld_last parks the controller in ERROR with load_err set until a
// reload request.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous, active-low reset
//   bus  - imem_load_if.slave (loader, memory, fetch and status signals)
module imem_load_controller #(
    parameter int          DEPTH     = 16,
    parameter int          ADDR_STEP = 2,
    parameter logic [15:0] NOP_WORD  = 16'h0000
) (
    input logic        clk,
    input logic        rst,
    imem_load_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [15:0]        load_end_q, load_end_nx;
    logic               err_q, err_nx;

    logic [15:0]        boot_addr;
    logic               handshake;
    logic [15:0]        mem_addr_c;
    logic [15:0]        instr_c;
    logic               flush_c;

    // cnt never exceeds DEPTH-1 while in BOOT, so boot_addr stays below
    // DEPTH*ADDR_STEP whenever it drives the memory.
    assign boot_addr = 16'(cnt) * 16'(ADDR_STEP);

    // Registered-state decodes: glitch-free.
    assign bus.ld_ready  = (state == BOOT);
    assign bus.core_hold = (state != RUN);
    assign bus.load_end  = load_end_q;
    assign bus.load_err  = err_q;

    // Write happens in the same cycle as the handshake.
    assign handshake     = bus.ld_valid & bus.ld_ready;
    assign bus.mem_we    = handshake;
    assign bus.mem_wdata = bus.ld_data;

    assign bus.mem_addr   = mem_addr_c;
    assign bus.instr_out  = instr_c;
    assign bus.core_flush = flush_c;

    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        load_end_nx = load_end_q;
        err_nx      = err_q;
        mem_addr_c  = bus.fetch_addr;
        instr_c     = NOP_WORD;
        flush_c     = 1'b0;

        case (state)
            BOOT: begin
                mem_addr_c = boot_addr;
                if (handshake) begin
                    if (bus.ld_last) begin
                        load_end_nx = boot_addr + 16'(ADDR_STEP);
                        cnt_nx      = cnt + CNT_W'(1);
                        state_nx    = START;
                    end else if (cnt == CNT_W'(DEPTH - 1)) begin
                        // Last slot filled but the program is not finished.
                        err_nx   = 1'b1;
                        state_nx = ERROR;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end

            START: begin
                flush_c  = 1'b1;
                state_nx = RUN;
            end

            RUN: begin
                if (bus.reload) begin
                    // Reload wins over the fetch: the flushed slot gets a NOP.
                    flush_c     = 1'b1;
                    cnt_nx      = '0;
                    load_end_nx = '0;
                    state_nx    = BOOT;
                end else if (bus.fetch_addr < load_end_q) begin
                    instr_c = bus.mem_rdata;
                end
            end

            ERROR: begin
                if (bus.reload) begin
                    flush_c     = 1'b1;
                    err_nx      = 1'b0;
                    cnt_nx      = '0;
                    load_end_nx = '0;
                    state_nx    = BOOT;
                end
            end

            default: state_nx = BOOT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= BOOT;
            cnt        <= '0;
            load_end_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            load_end_q <= load_end_nx;
            err_q      <= err_nx;
        end
    end

endmodule
